// File: rtl/risc16_bus_responder.sv
// Memory-side responder for the risc16 instruction/data buses: shared RAM, TX FIFO, STATUS and CYCLE MMIO.
// Optional write protection of the low instruction region is enabled by defining RISC16_RESP_IMEM_WP_EN.
module risc16_bus_responder #(
    parameter int unsigned MEM_AWIDTH = 12,
    parameter logic [15:0] MMIO_BASE  = 16'hFF00,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] IMEM_LIMIT = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_oe,
    output logic [15:0] i_dout,
    input  logic [15:0] d_addr,
    input  logic        d_oe,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_we,
    output logic [15:0] d_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        status_ovf
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [14:0] MMIO_W = MMIO_BASE[15:1];
`ifdef RISC16_RESP_IMEM_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    logic [15:0]   mem [2**MEM_AWIDTH];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          ovf, wp_hit;
    logic [15:0]   cycle_cnt;

    logic                  i_mmio, d_mmio, any_we;
    logic [MEM_AWIDTH-1:0] i_idx, d_idx;
    logic [14:0]           d_woff;
    logic                  sel_tx, sel_status, sel_cycle;
    logic                  full, empty, push, pop, push_ok, drop;
    logic [7:0]            push_byte;
    logic                  ram_wr_req, wp_block, ram_wr;
    logic [15:0]           status_word;

    assign i_mmio     = i_addr >= MMIO_BASE;
    assign d_mmio     = d_addr >= MMIO_BASE;
    assign i_idx      = i_addr[MEM_AWIDTH:1];
    assign d_idx      = d_addr[MEM_AWIDTH:1];
    assign d_woff     = d_addr[15:1] - MMIO_W;
    assign any_we     = |d_we;
    assign sel_tx     = d_mmio && (d_woff == 15'd0);
    assign sel_status = d_mmio && (d_woff == 15'd1);
    assign sel_cycle  = d_mmio && (d_woff == 15'd2);

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign tx_valid  = !empty;
    assign push      = sel_tx && any_we;
    assign pop       = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign push_byte = d_we[1] ? d_wdata[7:0] : d_wdata[15:8];

    assign ram_wr_req = !d_mmio && any_we;
    assign wp_block   = WP_EN && ram_wr_req && (d_addr < IMEM_LIMIT);
    assign ram_wr     = ram_wr_req && !wp_block && !rst;

    assign status_word = {8'(count), 4'b0000, wp_hit, ovf, full, empty};
    assign status_ovf  = ovf;
    assign tx_data     = tx_valid ? fifo_mem[rd_ptr] : '0;
    assign i_dout      = (i_oe && !i_mmio) ? mem[i_idx] : '0;

    always_comb begin
        d_rdata = '0;
        if (d_oe) begin
            if (!d_mmio)         d_rdata = mem[d_idx];
            else if (sel_status) d_rdata = status_word;
            else if (sel_cycle)  d_rdata = cycle_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            if (d_we[0]) mem[d_idx][15:8] <= d_wdata[15:8];
            if (d_we[1]) mem[d_idx][7:0]  <= d_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            wp_hit    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop)                                    ovf <= 1'b1;
            else if (sel_status && any_we && d_wdata[2]) ovf <= 1'b0;

            if (wp_block)                                wp_hit <= 1'b1;
            else if (sel_status && any_we && d_wdata[3]) wp_hit <= 1'b0;

            if (sel_cycle && d_we == 2'b11) cycle_cnt <= d_wdata;
            else                            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_risc16_bus_responder.sv
// Scoreboard bench for risc16_bus_responder: a byte-queue/associative-array reference model
// predicts every read and TX pop; a negedge monitor compares whenever the DUT presents output.
module tb_risc16_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_addr = '0;
    logic        i_oe = 1'b0;
    logic [15:0] i_dout;
    logic [15:0] d_addr = '0;
    logic        d_oe = 1'b0;
    logic [15:0] d_wdata = '0;
    logic [1:0]  d_we = '0;
    logic [15:0] d_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        status_ovf;

    risc16_bus_responder #(
        .MEM_AWIDTH(12),
        .MMIO_BASE (16'hFF00),
        .FIFO_DEPTH(8),
        .IMEM_LIMIT(16'h0800)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_oe      (i_oe),
        .i_dout    (i_dout),
        .d_addr    (d_addr),
        .d_oe      (d_oe),
        .d_wdata   (d_wdata),
        .d_we      (d_we),
        .d_rdata   (d_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .status_ovf(status_ovf)
    );

    always #5 clk = ~clk;

    localparam int DEPTH = 8;
`ifdef RISC16_RESP_IMEM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        bit          d_known;
        logic [15:0] i;
        bit          i_known;
        bit          ovf;
        bit          txv;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [7:0]  tx_q[$];

    // Reference model state
    logic [15:0] mem_m [int];
    logic [7:0]  fq[$];
    bit          m_ovf = 1'b0;
    bit          m_wp = 1'b0;
    logic [15:0] m_cyc = '0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % 4096;
    endfunction

    function automatic logic [15:0] status_m();
        int n = fq.size();
        return {8'(n), 4'b0000, m_wp, m_ovf, n == DEPTH, n == 0};
    endfunction

    task automatic model_reset();
        fq.delete();
        m_ovf = 1'b0;
        m_wp  = 1'b0;
        m_cyc = '0;
    endtask

    task automatic model_edge(input logic [15:0] da, input logic [1:0] we,
                              input logic [15:0] wd, input bit trdy);
        bit mm = da >= 16'hFF00;
        int woff = (int'(da) - 32'hFF00) / 2;
        int k = widx(da);
        logic [15:0] w;
        if (trdy && fq.size() > 0) void'(fq.pop_front());
        if (mm && we != 2'b00) begin
            if (woff == 0) begin
                if (fq.size() < DEPTH) fq.push_back(we[1] ? wd[7:0] : wd[15:8]);
                else m_ovf = 1'b1;
            end else if (woff == 1) begin
                if (wd[2]) m_ovf = 1'b0;
                if (wd[3]) m_wp = 1'b0;
            end
        end
        if (mm && woff == 2 && we == 2'b11) m_cyc = wd;
        else m_cyc = m_cyc + 16'd1;
        if (!mm && we != 2'b00) begin
            if (WP && da < 16'h0800) m_wp = 1'b1;
            else if (we == 2'b11) mem_m[k] = wd;
            else if (mem_m.exists(k)) begin
                w = mem_m[k];
                if (we[0]) w[15:8] = wd[15:8];
                if (we[1]) w[7:0] = wd[7:0];
                mem_m[k] = w;
            end
        end
    endtask

    task automatic step(input bit r, input logic [15:0] da, input bit doe, input logic [1:0] we,
                        input logic [15:0] wd, input logic [15:0] ia, input bit ioe, input bit trdy);
        rd_exp_t e;
        int woff;
        @(posedge clk);
        #1;
        rst = r; d_addr = da; d_oe = doe; d_we = we; d_wdata = wd;
        i_addr = ia; i_oe = ioe; tx_ready = trdy;
        if (r) model_reset();
        if (doe || ioe) begin
            e.d = '0; e.d_known = 1'b1; e.i = '0; e.i_known = 1'b1;
            if (doe) begin
                if (da >= 16'hFF00) begin
                    woff = (int'(da) - 32'hFF00) / 2;
                    if (woff == 1) e.d = status_m();
                    else if (woff == 2) e.d = m_cyc;
                end else if (mem_m.exists(widx(da))) e.d = mem_m[widx(da)];
                else e.d_known = 1'b0;
            end
            if (ioe && ia < 16'hFF00) begin
                if (mem_m.exists(widx(ia))) e.i = mem_m[widx(ia)];
                else e.i_known = 1'b0;
            end
            e.ovf = m_ovf;
            e.txv = fq.size() > 0;
            rd_q.push_back(e);
        end
        if (!r && trdy && fq.size() > 0) tx_q.push_back(fq[0]);
        if (!r) model_edge(da, we, wd, trdy);
    endtask

    task automatic sw(input logic [15:0] a, input logic [15:0] v, input logic [1:0] we);
        step(1'b0, a, 1'b0, we, v, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b0, a, 1'b1, 2'b00, 16'h0000, a, 1'b1, 1'b0);
    endtask

    task automatic idle(input bit trdy);
        step(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, trdy);
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        logic [7:0] b;
        if (d_oe || i_oe) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_scoreboard: read sampled with no expectation at %0t", $time);
            end else begin
                e = rd_q.pop_front();
                if (e.d_known) chk("d_rdata", d_rdata, e.d);
                if (e.i_known) chk("i_dout", i_dout, e.i);
                chk("status_ovf", 16'(status_ovf), 16'(e.ovf));
                chk("tx_valid", 16'(tx_valid), 16'(e.txv));
            end
        end
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_scoreboard: pop of %h with none expected at %0t", tx_data, $time);
            end else begin
                b = tx_q.pop_front();
                chk("tx_data", 16'(tx_data), 16'(b));
            end
        end
    end

    logic [15:0] ram_pool [8] = '{16'h0100, 16'h0102, 16'h0200, 16'h0010,
                                  16'h0800, 16'h2100, 16'h0FFE, 16'h1FFE};
    logic [15:0] mmio_pool [8] = '{16'hFF00, 16'hFF01, 16'hFF02, 16'hFF03,
                                   16'hFF04, 16'hFF05, 16'hFF08, 16'hFFFE};

    initial begin
        logic [15:0] da, ia;
        // Reset state
        step(1'b1, 16'hFF02, 1'b1, 2'b00, 16'h0000, 16'hFF00, 1'b1, 1'b1);
        step(1'b1, 16'hFF04, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        rd(16'hFF02);
        rd(16'hFF04);
        // Word store, data and instruction read-back
        sw(16'h0100, 16'hA1B2, 2'b11);
        rd(16'h0100);
        // Byte lanes
        sw(16'h0200, 16'h0000, 2'b11);
        sw(16'h0200, 16'h5500, 2'b01);
        sw(16'h0201, 16'h0066, 2'b10);
        rd(16'h0200);
        // Same-cycle read and write returns old contents
        step(1'b0, 16'h0200, 1'b1, 2'b11, 16'h1234, 16'h0200, 1'b1, 1'b0);
        rd(16'h0200);
        // FIFO push then drain
        sw(16'hFF00, 16'h0041, 2'b10);
        sw(16'hFF00, 16'h4200, 2'b01);
        sw(16'hFF01, 16'h0043, 2'b11);
        rd(16'hFF02);
        for (int i = 0; i < 4; i++) idle(1'b1);
        rd(16'hFF02);
        // Overflow, clear, and push-with-pop while full
        for (int i = 0; i < 9; i++) sw(16'hFF00, 16'(16'h0060 + i), 2'b10);
        rd(16'hFF02);
        sw(16'hFF02, 16'h0004, 2'b11);
        rd(16'hFF02);
        step(1'b0, 16'hFF00, 1'b1, 2'b10, 16'h0077, 16'h0000, 1'b0, 1'b1);
        rd(16'hFF02);
        for (int i = 0; i < 9; i++) idle(1'b1);
        rd(16'hFF02);
        // CYCLE load, wrap, partial write ignored, async reset
        sw(16'hFF04, 16'hFFFE, 2'b11);
        rd(16'hFF04);
        rd(16'hFF04);
        rd(16'hFF04);
        sw(16'hFF04, 16'h0000, 2'b01);
        rd(16'hFF04);
        sw(16'hFF00, 16'h0099, 2'b10);
        step(1'b1, 16'hFF04, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h0100, 1'b1, 2'b11, 16'hDEAD, 16'h0000, 1'b0, 1'b0);
        rd(16'h0100);
        rd(16'hFF02);
        // Instruction-region protection
        sw(16'h0010, 16'h1111, 2'b11);
        rd(16'hFF02);
        sw(16'h0800, 16'h2222, 2'b11);
        rd(16'h0800);
        rd(16'h0010);
        sw(16'hFF02, 16'h0008, 2'b11);
        rd(16'hFF02);
        // Randomised traffic over an initialised address pool
        for (int i = 0; i < 8; i++) sw(ram_pool[i], 16'($urandom), 2'b11);
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 2))
                0:       da = 16'hFF00;
                1:       da = mmio_pool[$urandom_range(0, 7)];
                default: da = ram_pool[$urandom_range(0, 7)];
            endcase
            ia = ($urandom_range(0, 7) == 0) ? 16'hFF10 : ram_pool[$urandom_range(0, 7)];
            step($urandom_range(0, 199) == 0, da, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 16'($urandom), ia, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0);
        end
        idle(1'b0);
        @(negedge clk);
        #1;
        chk("rd_queue_left", 16'(rd_q.size()), 16'd0);
        chk("tx_queue_left", 16'(tx_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
